// File: rtl/fifo_drain_adapter.sv
// Pops a synchronous FIFO into a 2-entry skid buffer that drives a registered val/rdy stream.
// Latency 1 cycle (pop to out_val); out_rdy never reaches fifo_rd_en_o, and popping stops once both entries are held.
module fifo_drain_adapter #(
    parameter int DATA_NBITS = 32,
    parameter int CNT_NBITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_NBITS-1:0] fifo_rd_data_i,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [DATA_NBITS-1:0] out_msg,
    output logic [1:0]            occupancy_o,
    output logic [CNT_NBITS-1:0]  pop_count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_NBITS-1:0] entry0;
    logic [DATA_NBITS-1:0] entry1;
    logic                  val_q;
    logic [CNT_NBITS-1:0]  pop_cnt;
    logic                  pop;
    logic                  deq;

    // Pop depends only on registered state and the empty flag, so downstream ready never loops back to the FIFO.
    assign pop          = ~reset & ~fifo_empty_i & (state != FULL);
    assign deq          = val_q & out_rdy;
    assign fifo_rd_en_o = pop;
    assign out_val      = val_q;
    assign out_msg      = entry0;
    assign occupancy_o  = state;
    assign pop_count_o  = pop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            entry0  <= '0;
            entry1  <= '0;
            val_q   <= 1'b0;
            pop_cnt <= '0;
        end else begin
            if (pop) begin
                pop_cnt <= pop_cnt + 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (pop) begin
                        entry0 <= fifo_rd_data_i;
                        state  <= ONE;
                        val_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (pop && deq) begin
                        entry0 <= fifo_rd_data_i;
                    end else if (pop) begin
                        entry1 <= fifo_rd_data_i;
                        state  <= FULL;
                    end else if (deq) begin
                        entry0 <= '0;
                        state  <= EMPTY;
                        val_q  <= 1'b0;
                    end
                end
                FULL: begin
                    if (deq) begin
                        entry0 <= entry1;
                        entry1 <= '0;
                        state  <= ONE;
                    end
                end
                default: begin
                    entry0 <= '0;
                    entry1 <= '0;
                    state  <= EMPTY;
                    val_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_adapter.sv
// Bench for fifo_drain_adapter: directed scenarios then random traffic, checked against a queue-level model.
module tb_fifo_drain_adapter;

    logic        clk;
    logic        reset;
    logic        fifo_empty_i;
    logic [31:0] fifo_rd_data_i;
    logic        out_rdy;

    logic        fifo_rd_en_o;
    logic        out_val;
    logic [31:0] out_msg;
    logic [1:0]  occupancy_o;
    logic [15:0] pop_count_o;

    logic        fifo_rd_en_o2;
    logic        out_val2;
    logic [31:0] out_msg2;
    logic [1:0]  occupancy_o2;
    logic [1:0]  pop_count_o2;

    fifo_drain_adapter #(.DATA_NBITS(32), .CNT_NBITS(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .fifo_rd_data_i (fifo_rd_data_i),
        .out_val        (out_val),
        .out_rdy        (out_rdy),
        .out_msg        (out_msg),
        .occupancy_o    (occupancy_o),
        .pop_count_o    (pop_count_o)
    );

    // Narrow counter instance sees identical traffic so counter wrap is exercised continuously.
    fifo_drain_adapter #(.DATA_NBITS(32), .CNT_NBITS(2)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_en_o   (fifo_rd_en_o2),
        .fifo_rd_data_i (fifo_rd_data_i),
        .out_val        (out_val2),
        .out_rdy        (out_rdy),
        .out_msg        (out_msg2),
        .occupancy_o    (occupancy_o2),
        .pop_count_o    (pop_count_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          pops   = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] rx_q[$];
    logic        rec = 1'b0;
    logic        exp_pop;
    logic        exp_val;
    logic [31:0] exp_msg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs, then advance the model past the next rising edge.
    task automatic cycle(input logic rst, input logic rdy);
        @(negedge clk);
        reset        = rst;
        out_rdy      = rdy;
        exp_val      = (buf_q.size() != 0);
        exp_msg      = exp_val ? buf_q[0] : 32'h0;
        exp_pop      = !rst && (fifo_q.size() != 0) && (buf_q.size() < 2);
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_rd_data_i = exp_pop ? fifo_q[0] : $urandom();
        #1;
        chk("rd_en",      {31'b0, fifo_rd_en_o},  {31'b0, exp_pop});
        chk("out_val",    {31'b0, out_val},       {31'b0, exp_val});
        chk("out_msg",    out_msg,                exp_msg);
        chk("occupancy",  {30'b0, occupancy_o},   32'(buf_q.size()));
        chk("pop_count",  {16'b0, pop_count_o},   32'(pops % 65536));
        chk("rd_en_n",    {31'b0, fifo_rd_en_o2}, {31'b0, exp_pop});
        chk("out_val_n",  {31'b0, out_val2},      {31'b0, exp_val});
        chk("out_msg_n",  out_msg2,               exp_msg);
        chk("occ_n",      {30'b0, occupancy_o2},  32'(buf_q.size()));
        chk("pop_count2", {30'b0, pop_count_o2},  32'(pops % 4));
        if (rec && out_val && rdy) rx_q.push_back(out_msg);
        if (rst) begin
            buf_q.delete();
            pops = 0;
        end else begin
            if (exp_val && rdy) void'(buf_q.pop_front());
            if (exp_pop) begin
                buf_q.push_back(fifo_q.pop_front());
                pops++;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        out_rdy        = 1'b0;
        fifo_empty_i   = 1'b1;
        fifo_rd_data_i = 32'h0;
        @(posedge clk);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);

        // Streaming at full rate.
        fifo_q = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);

        // Backpressure, then release.
        fifo_q = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);

        // Alternating ready with ordered delivery check.
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h10 + i);
        rec = 1'b1;
        for (int i = 0; i < 24; i++) cycle(1'b0, (i % 2) == 0);
        rec = 1'b0;
        chk("rx_count", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("rx_order", (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF, 32'h10 + i);

        // Empty FIFO idle.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

        // Reset while full with more data waiting.
        fifo_q = '{32'hB1, 32'hB2, 32'hC1};
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back($urandom());
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_drain_adapter.md
Name: fifo_drain_adapter

Overview:
- Read-side companion to the team's depth-parameterised synchronous FIFO, which has an empty flag, a read enable, and read data that is valid only in the same cycle as the read enable.
- Issues FIFO pops and converts them into a registered val/rdy output stream through a 2-entry skid buffer.
- Gives full throughput with no combinational path from out_rdy to fifo_rd_en_o. Sits between the FIFO and any downstream val/rdy consumer.

Parameters:
DATA_NBITS, 32, width of FIFO data and output message
CNT_NBITS, 16, width of the free-running popped-item counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
fifo_empty_i  input  1  FIFO empty flag
fifo_rd_en_o  output  1  FIFO pop request; data sampled the same cycle
fifo_rd_data_i  input  DATA_NBITS  FIFO read data; valid only while fifo_rd_en_o=1
out_val  output  1  output message valid
out_rdy  input  1  downstream ready
out_msg  output  DATA_NBITS  output message, driven from a register
occupancy_o  output  2  skid-buffer entries held (0..2)
pop_count_o  output  CNT_NBITS  total FIFO pops since reset, wraps modulo 2^CNT_NBITS

Behaviour:
- State:
  - entry0 is the head and drives out_msg.
  - entry1 is the second entry.
  - count holds 0..2. States are EMPTY (0), ONE (1), FULL (2); occupancy_o = count.
- pop = ~reset & ~fifo_empty_i & (count != 2).
  - fifo_rd_en_o = pop, combinational from registered count and fifo_empty_i only.
  - out_rdy must not affect pop.
- deq = out_val & out_rdy. out_val = (count != 0).
- out_msg = entry0. It is 0 whenever count = 0, because entry0 is cleared on any transition to EMPTY.
- Next state, count' = count + pop - deq:
  - EMPTY:
    - pop -> entry0 <= rd_data, ONE.
    - else stay.
  - ONE:
    - pop & deq -> entry0 <= rd_data, stay ONE.
    - pop & ~deq -> entry1 <= rd_data, FULL.
    - ~pop & deq -> entry0 <= 0, EMPTY.
    - neither -> hold.
  - FULL (pop is 0 here):
    - deq -> entry0 <= entry1, entry1 <= 0, ONE.
    - else hold.
- Latency: data popped in cycle N appears on out_msg with out_val=1 in cycle N+1.
- Throughput: sustained 1 item/cycle while the FIFO is non-empty and out_rdy=1, with count steady at 1.
- Backpressure: with out_rdy=0, at most 2 items are popped, then fifo_rd_en_o drops to 0.
- Stability: while out_val=1 and out_rdy=0, out_msg is held stable.
- pop_count_o increments by 1 on every cycle with pop=1 and wraps all-ones -> 0.
- Reset:
  - count=0, entry0=entry1=0, pop_count_o=0.
  - fifo_rd_en_o=0 in any cycle where reset=1.
  - out_val=0 in the cycle after reset is asserted.
  - Reset mid-stream discards buffered items without popping further.
- Reset has priority over pop and deq in the same cycle.
- fifo_rd_data_i is ignored in any cycle with fifo_rd_en_o=0. The FIFO drives 0 there, and the adapter must not depend on that value.

Test Plan:
1. Reset, then FIFO holding 0xA1,0xA2,0xA3, out_rdy=1:
   - fifo_rd_en_o=1 for 3 consecutive cycles.
   - out_msg 0xA1,0xA2,0xA3 on consecutive cycles, each one cycle after its pop.
   - pop_count_o=3, occupancy_o returns to 0.
2. Same FIFO contents, out_rdy=0:
   - exactly 2 pops, occupancy_o=2, fifo_rd_en_o=0 thereafter, out_msg=0xA1 held stable.
   - Raise out_rdy: outputs 0xA1,0xA2,0xA3 in order, pop of 0xA3 occurs the cycle count falls to 1.
3. Alternating out_rdy (1,0,1,0...) with 8 items 0x10..0x17:
   - all 8 delivered in order, no duplicates or drops, occupancy_o never exceeds 2.
4. Empty FIFO (fifo_empty_i=1), out_rdy=1 for 10 cycles:
   - fifo_rd_en_o=0, out_val=0, out_msg=0, pop_count_o unchanged.
5. FULL with 0xB1,0xB2 buffered, assert reset for 1 cycle while fifo_empty_i=0:
   - fifo_rd_en_o=0 that cycle.
   - next cycle occupancy_o=0, out_val=0, pop_count_o=0.
   - following cycle pops resume.
6. CNT_NBITS=2, 5 pops -> pop_count_o sequence 1,2,3,0,1.
